// File: rtl/fifo_traffic_checker.sv
// FIFO traffic generator and read-back checker.
// Writes a counting pattern, verifies wide read words and reports errors.
module fifo_traffic_checker #(
    parameter int WR_WIDTH  = 16,
    parameter int RATIO     = 2,
    parameter int CNT_WIDTH = 16,
    parameter int HB_WIDTH  = 20
) (
    input  logic                         clk_i,
    input  logic                         a_rst_i,
    input  logic                         enable_i,
    input  logic                         wr_hold_i,
    input  logic                         rd_hold_i,
    input  logic                         pattern_sel_i,
    input  logic                         fifo_rst_busy_i,
    input  logic                         fifo_full_i,
    input  logic                         fifo_empty_i,
    input  logic                         fifo_prog_full_i,
    output logic                         fifo_wr_en_o,
    output logic [WR_WIDTH-1:0]          fifo_wdata_o,
    output logic                         fifo_rd_en_o,
    input  logic [WR_WIDTH*RATIO-1:0]    fifo_rdata_i,
    input  logic                         fifo_rd_valid_i,
    output logic                         error_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    output logic [WR_WIDTH*RATIO-1:0]    first_err_o,
    output logic [CNT_WIDTH-1:0]         rd_word_cnt_o,
    output logic                         heartbeat_o,
    output logic [1:0]                   state_o
);

    localparam int RD_WIDTH = WR_WIDTH * RATIO;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RST = 2'd1;
    localparam logic [1:0] ST_FILL     = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_pat_sel;
    logic [WR_WIDTH-1:0]  r_wr_cnt;
    logic [WR_WIDTH-1:0]  r_exp_cnt;
    logic                 r_error;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [RD_WIDTH-1:0]  r_first_err;
    logic [CNT_WIDTH-1:0] r_rd_cnt;
    logic [HB_WIDTH-1:0]  r_hb_cnt;
    logic                 r_hb;

    logic                 w_active;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_rd_fire;
    logic                 w_mismatch;
    logic [RD_WIDTH-1:0]  w_exp_word;

    function automatic logic [WR_WIDTH-1:0] f_pat(
        input logic [WR_WIDTH-1:0] v,
        input logic                inv
    );
        return inv ? ~v : v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = ST_WAIT_RST;
                ST_WAIT_RST: if (!fifo_rst_busy_i) w_state_nxt = ST_FILL;
                ST_FILL:     if (fifo_prog_full_i) w_state_nxt = ST_RUN;
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_active = (r_state != ST_IDLE);

    assign w_wr_en = ((r_state == ST_FILL) || (r_state == ST_RUN))
                   && !wr_hold_i && !fifo_full_i && !fifo_rst_busy_i;

    assign w_rd_en = (r_state == ST_RUN)
                   && !rd_hold_i && !fifo_empty_i && !fifo_rst_busy_i;

    // Pattern polarity is latched only while idle so a run never mixes polarities.
    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_pat_sel <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_pat_sel <= pattern_sel_i;
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_wr_cnt <= WR_WIDTH'(1);
        end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + WR_WIDTH'(1);
        end
    end

    // Earliest pattern value lands in the most-significant slice.
    always_comb begin
        w_exp_word = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_exp_word[(RATIO-1-k)*WR_WIDTH +: WR_WIDTH] =
                f_pat(r_exp_cnt + WR_WIDTH'(k), r_pat_sel);
        end
    end

    assign w_rd_fire  = fifo_rd_valid_i && w_active;
    assign w_mismatch = w_rd_fire && (fifo_rdata_i != w_exp_word);

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_exp_cnt <= WR_WIDTH'(1);
            r_rd_cnt  <= '0;
        end else if (w_rd_fire) begin
            r_exp_cnt <= r_exp_cnt + WR_WIDTH'(RATIO);
            r_rd_cnt  <= r_rd_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_error     <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else if (w_mismatch) begin
            r_error <= 1'b1;
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            if (!r_error) begin
                r_first_err <= fifo_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else begin
            r_hb_cnt <= r_hb_cnt + HB_WIDTH'(1);
            if (r_hb_cnt == '1) begin
                r_hb <= ~r_hb;
            end
        end
    end

    assign fifo_wr_en_o  = w_wr_en;
    assign fifo_wdata_o  = f_pat(r_wr_cnt, r_pat_sel);
    assign fifo_rd_en_o  = w_rd_en;
    assign error_o       = r_error;
    assign err_cnt_o     = r_err_cnt;
    assign first_err_o   = r_first_err;
    assign rd_word_cnt_o = r_rd_cnt;
    assign heartbeat_o   = r_hb;
    assign state_o       = r_state;

endmodule
